systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Drives the input side of the 8x8 PE cluster: the 128-bit activation bus, the 128-bit weight bus, and the 8-bit per-row done strobes.
- Accepts one k-step per handshake. Each beat is one activation column (8 lanes) plus one weight row (8 lanes).
- Applies the diagonal systolic skew: lane i is delayed i cycles.
- Tags the last beat of a K-length job and converts it into per-row done pulses, then reports job completion.

Parameters:
- LANES, 8, number of rows/columns (lanes per bus).
- DW, 16, data width per lane.
- KW, 8, width of the job length field.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  global enable; low freezes all state and outputs.
- start  input  1  one-cycle job start request.
- k_len  input  KW  number of beats in the job; sampled on an accepted start.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready && en.
- in_act  input  LANES*DW  activation column; lane i = bits [(i+1)*DW-1 : i*DW].
- in_wgt  input  LANES*DW  weight row; same lane packing as in_act.
- activations  output  LANES*DW  skewed activation bus to the cluster.
- weights  output  LANES*DW  skewed weight bus to the cluster.
- done  output  LANES  per-row last-element strobe.
- busy  output  1  high while not IDLE.
- finish  output  1  one-cycle pulse at job completion.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE; beat counter = 0.
  - All delay-line stages and tag bits = 0.
  - activations = 0, weights = 0, done = 0, in_ready = 0, busy = 0, finish = 0.
  - Reset mid-job aborts the job; no finish pulse is produced.
- en low: no state change. All registers, including outputs, hold their values. No beat is accepted, because acceptance requires en.
- FSM states: IDLE, STREAM, FLUSH.
- IDLE:
  - in_ready = 0.
  - Delay lines shift zeros.
  - start with k_len != 0: latch k_len, clear the counter, go to STREAM.
  - start with k_len == 0: stay in IDLE; finish pulses in the next cycle; done stays 0.
- STREAM:
  - in_ready = 1.
  - Accepted beat: lane i of in_act and in_wgt enters delay line i. The tag bit entering line i is set when counter == k_len-1. The counter increments.
  - Cycle with no accepted beat: a zero bubble (zero data, tag 0) enters every lane, so lanes stay aligned and MAC results are unaffected.
  - On the accept where counter == k_len-1: go to FLUSH.
  - start is ignored in STREAM and FLUSH.
- FLUSH:
  - in_ready = 0; zeros shift in.
  - Stays until the last tag leaves lane LANES-1, i.e. LANES-1 shifting cycles after the last accept.
  - finish pulses in the same cycle done[LANES-1] is high; next state is IDLE.
- Latency: an element accepted in cycle t appears on lane i of activations/weights at cycle t+1+i. Lane 0 has a single output register.
- done[i] is high exactly one cycle, in the same cycle lane i presents the job's last activation. done[i] pulses at t_last+1+i.
- Back-to-back jobs: a new start is accepted only in IDLE, so jobs never overlap inside the delay lines.
- busy = (state != IDLE).
- Data is passed through unmodified; no arithmetic on the data path. The counter is KW bits with no wrap, since k_len <= 2^KW-1.

Decomposition:
- Shared package: LANES, DW, KW constants; the FSM state encoding (IDLE = 0, STREAM = 1, FLUSH = 2).
- One sub-module, skew_delay_line (parameters DEPTH, W):
  - DEPTH-stage shift register with en hold and async clear.
  - Instantiated per lane for activations, weights, and the tag bit.
  - DEPTH = i+1 for lane i.

Test Plan:
- Reset mid-FLUSH: assert rst_n low during FLUSH -> all outputs 0 immediately; busy = 0; no finish pulse.
- k_len = 1, single beat, in_act lane i = 0x0100+i, accepted at cycle t:
  - activations lane i = 0x0100+i exactly at t+1+i, and zero otherwise.
  - done[i] pulses at t+1+i.
  - finish pulses at t+8.
- k_len = 4, continuous valid, weights lane j = beat index k*16+j:
  - lane j of weights shows the sequence 0..3 (+j) starting at t0+1+j.
  - done = 8'b0000_0001 at t0+4, then one bit per cycle up to bit 7.
- k_len = 3 with in_valid low for 2 cycles after beat 0:
  - two zero bubbles on all lanes; skew preserved.
  - last-element done timing shifts by exactly 2 cycles.
- en low for 3 cycles during STREAM -> outputs frozen, in_ready ineffective; after en returns, sequence resumes with no lost or duplicated beat.
- start with k_len = 0 -> finish next cycle; busy stays 0; done stays 0. Also: start asserted during STREAM is ignored and does not restart the counter.

Source files
------------

// File: rtl/systolic_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder_pkg
// Brief    : Shared constants and FSM encoding for the systolic skew feeder.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_skew_feeder_pkg;

  // Cluster geometry and field widths
  localparam int C_LANES = 8;
  localparam int C_DW    = 16;
  localparam int C_KW    = 8;

  // Feeder control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

endpackage : systolic_skew_feeder_pkg
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : skew_delay_line
// Brief    : DEPTH-stage shift register with enable hold and async clear.
//            One instance per lane sets that lane's systolic skew.
// Revision : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] r_stage;

  // Shift one stage per enabled cycle; every stage holds while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (en) begin
      r_stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule : skew_delay_line
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder
// Brief    : Feeds activation/weight buses of the PE cluster with diagonal
//            skew (lane i delayed i cycles), and turns the last beat of a
//            K-length job into per-row done strobes plus a finish pulse.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int LANES = C_LANES,
  parameter int DW    = C_DW,
  parameter int KW    = C_KW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_act,
  input  logic [LANES*DW-1:0] in_wgt,
  output logic [LANES*DW-1:0] activations,
  output logic [LANES*DW-1:0] weights,
  output logic [LANES-1:0]    done,
  output logic                busy,
  output logic                finish
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [KW-1:0] r_cnt;
  logic [KW-1:0] r_klen;
  logic          r_zero_fin;
  logic          w_accept;
  logic          w_last;
  logic          w_job_start;

  assign in_ready    = (r_state == STREAM);
  assign busy        = (r_state != IDLE);
  assign w_accept    = in_valid && in_ready && en;
  assign w_last      = w_accept && (r_cnt == (r_klen - KW'(1)));
  assign w_job_start = (r_state == IDLE) && start && (k_len != '0);

  // Next-state logic; FLUSH ends in the cycle the last tag leaves the top lane
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_job_start)      w_state_nxt = STREAM;
      STREAM:  if (w_last)           w_state_nxt = FLUSH;
      FLUSH:   if (done[LANES-1])    w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  // State register, frozen while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (en) begin
      r_state <= w_state_nxt;
    end
  end

  // Job length latch and beat counter; the counter never wraps since k_len fits KW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_klen <= '0;
    end else if (en) begin
      if (w_job_start) begin
        r_klen <= k_len;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + KW'(1);
      end
    end
  end

  // An empty job completes on the cycle after its start request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_fin <= 1'b0;
    end else if (en) begin
      r_zero_fin <= (r_state == IDLE) && start && (k_len == '0);
    end
  end

  // Built purely from registers, so it holds with them while en is low
  assign finish = r_zero_fin || ((r_state == FLUSH) && done[LANES-1]);

  // Per-lane skew; unaccepted cycles inject zero bubbles to keep lanes aligned
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] w_act_d;
    logic [DW-1:0] w_wgt_d;

    assign w_act_d = w_accept ? in_act[i*DW +: DW] : '0;
    assign w_wgt_d = w_accept ? in_wgt[i*DW +: DW] : '0;

    skew_delay_line #(.DEPTH(i + 1), .W(DW)) u_act_line (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (w_act_d),
      .q     (activations[i*DW +: DW])
    );

    skew_delay_line #(.DEPTH(i + 1), .W(DW)) u_wgt_line (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (w_wgt_d),
      .q     (weights[i*DW +: DW])
    );

    skew_delay_line #(.DEPTH(i + 1), .W(1)) u_tag_line (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (w_last),
      .q     (done[i])
    );
  end : g_lane

endmodule : systolic_skew_feeder
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_skew_feeder
// Brief    : Directed self-checking bench for systolic_skew_feeder. A queue
//            holds expected outputs for the next LANES+1 cycles; each driven
//            beat writes its future lane values, each enabled cycle pops one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int KW    = 8;
  localparam int BW    = LANES * DW;

  typedef struct packed {
    logic [BW-1:0]    act;
    logic [BW-1:0]    wgt;
    logic [LANES-1:0] dn;
    logic             fin;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             start;
  logic [KW-1:0]    k_len;
  logic             in_valid;
  logic             in_ready;
  logic [BW-1:0]    in_act;
  logic [BW-1:0]    in_wgt;
  logic [BW-1:0]    activations;
  logic [BW-1:0]    weights;
  logic [LANES-1:0] done;
  logic             busy;
  logic             finish;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side job model
  exp_t          exp_q[$];
  int            m_mode;   // 0 idle, 1 stream, 2 flush
  logic [KW-1:0] m_cnt;
  logic [KW-1:0] m_klen;
  int            m_flush;

  systolic_skew_feeder #(.LANES(LANES), .DW(DW), .KW(KW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .start       (start),
    .k_len       (k_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_act      (in_act),
    .in_wgt      (in_wgt),
    .activations (activations),
    .weights     (weights),
    .done        (done),
    .busy        (busy),
    .finish      (finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [BW-1:0] pack(input int base);
    logic [BW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int k = 0; k <= LANES; k++) exp_q.push_back('0);
    m_mode  = 0;
    m_cnt   = '0;
    m_klen  = '0;
    m_flush = 0;
  endtask

  // One clock cycle: drive, check current outputs, update model, advance
  task automatic step(input logic st, input logic [KW-1:0] kl, input logic v,
                      input logic [BW-1:0] a, input logic [BW-1:0] w, input logic e);
    exp_t x;
    int   n_mode;
    start = st; k_len = kl; in_valid = v; in_act = a; in_wgt = w; en = e;
    #1;
    x = exp_q[0];
    chk("activations", activations, x.act);
    chk("weights", weights, x.wgt);
    chk("done", BW'(done), BW'(x.dn));
    chk("finish", BW'(finish), BW'(x.fin));
    chk("in_ready", BW'(in_ready), BW'(m_mode == 1));
    chk("busy", BW'(busy), BW'(m_mode != 0));
    n_mode = m_mode;
    if (e) begin
      case (m_mode)
        0: if (st) begin
          if (kl != '0) begin
            n_mode = 1; m_cnt = '0; m_klen = kl;
          end else begin
            x = exp_q[1]; x.fin = 1'b1; exp_q[1] = x;
          end
        end
        1: if (v) begin
          logic last;
          last = (m_cnt == m_klen - 1);
          for (int i = 0; i < LANES; i++) begin
            x = exp_q[1+i];
            x.act[i*DW +: DW] = a[i*DW +: DW];
            x.wgt[i*DW +: DW] = w[i*DW +: DW];
            x.dn[i] = last;
            exp_q[1+i] = x;
          end
          if (last) begin
            n_mode = 2; m_flush = LANES;
            x = exp_q[LANES]; x.fin = 1'b1; exp_q[LANES] = x;
          end
          m_cnt = m_cnt + 1;
        end
        default: begin
          m_flush--;
          if (m_flush == 0) n_mode = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (e) begin
      m_mode = n_mode;
      void'(exp_q.pop_front());
      exp_q.push_back('0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic beat(input int abase, input int wbase);
    step(1'b0, '0, 1'b1, pack(abase), pack(wbase), 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; k_len = '0;
    in_valid = 1'b0; in_act = '0; in_wgt = '0;
    model_clear();

    // Reset state
    #12;
    chk("rst activations", activations, '0);
    chk("rst weights", weights, '0);
    chk("rst done", BW'(done), '0);
    chk("rst in_ready", BW'(in_ready), '0);
    chk("rst busy", BW'(busy), '0);
    chk("rst finish", BW'(finish), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Single-beat job
    step(1'b1, 8'd1, 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, 1'b1, pack('h0100), pack('h0200), 1'b1);
    idle(10);

    // Four beats, continuous valid; weight lane j of beat k = k*16+j
    step(1'b1, 8'd4, 1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 4; k++) beat('h1000 + k*16, k*16);
    idle(10);

    // Three beats with a two-cycle valid gap after the first
    step(1'b1, 8'd3, 1'b0, '0, '0, 1'b1);
    beat('h2000, 'h3000);
    step(1'b0, '0, 1'b0, pack('h7777), pack('h7777), 1'b1);
    step(1'b0, '0, 1'b0, pack('h7777), pack('h7777), 1'b1);
    beat('h2010, 'h3010);
    beat('h2020, 'h3020);
    idle(10);

    // en low mid-stream (offered beats and start must be ignored), then a
    // start request during STREAM that must not restart the count
    step(1'b1, 8'd4, 1'b0, '0, '0, 1'b1);
    beat('h4000, 'h5000);
    beat('h4010, 'h5010);
    for (int k = 0; k < 3; k++)
      step(1'b1, 8'd2, 1'b1, pack('hdead), pack('hbeef), 1'b0);
    step(1'b1, 8'd9, 1'b1, pack('h4020), pack('h5020), 1'b1);
    beat('h4030, 'h5030);
    idle(10);

    // Empty job
    step(1'b1, 8'd0, 1'b0, '0, '0, 1'b1);
    idle(3);

    // Reset during FLUSH aborts the job without a finish pulse
    step(1'b1, 8'd2, 1'b0, '0, '0, 1'b1);
    beat('h6000, 'h6100);
    beat('h6010, 'h6110);
    idle(3);
    rst_n = 1'b0;
    #1;
    chk("midrst activations", activations, '0);
    chk("midrst weights", weights, '0);
    chk("midrst done", BW'(done), '0);
    chk("midrst busy", BW'(busy), '0);
    chk("midrst finish", BW'(finish), '0);
    chk("midrst in_ready", BW'(in_ready), '0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_systolic_skew_feeder
`default_nettype wire
